jesd204_sysref_ctrl: RTL and testbench
======================================

# jesd204_sysref_ctrl

Sequences JESD204 link bring-up in the `coreclk` domain. It synchronizes the board SYSREF, verifies that SYSREF is periodic at the programmed period, and aligns a local LMFC counter to it. While running it monitors SYSREF phase and holds the JESD core in reset until alignment is proven. It sits between the clocking block's `coreclk`/`sysref` outputs and the JESD204 core/transceiver reset inputs.

## Interface
- `LMFC_PERIOD`, 32: coreclk cycles per LMFC. Must be at least 2.
- `PERIOD_W`, 16: width of the SYSREF period counter.
- `LOCK_COUNT`, 4: consecutive correct SYSREF periods required for lock. Range 1–15.
- `RST_HOLD`, 16: coreclk cycles in RUN before `link_reset` deasserts.
- `coreclk` in 1: the single clock.
- `reset` in 1: synchronous, active-high.
- `sysref` in 1: SYSREF, asynchronous to `coreclk`.
- `arm` in 1: single-cycle request to (re)start alignment.
- `sysref_period` in PERIOD_W: expected SYSREF period in coreclk cycles. Must be a nonzero multiple of LMFC_PERIOD. Held static while armed.
- `lmfc_cnt` out $clog2(LMFC_PERIOD): LMFC phase.
- `lmfc_pulse` out 1: high when `lmfc_cnt==0` in RUN.
- `locked` out 1: SYSREF verified and LMFC aligned.
- `link_reset` out 1: reset to the JESD core and transceivers.
- `state` out 3: current FSM state.
- `err_period` out 1: sticky; a SYSREF edge arrived with the wrong spacing, or timed out.
- `err_phase` out 1: sticky; a SYSREF edge in RUN was misaligned with the LMFC.
- `realign_cnt` out 8: saturating count of lock losses.

## Operation
- Input path: a 2-flop synchronizer followed by a rising-edge detector produces `edge`, a 1-cycle pulse.
- `per_cnt`: loads 1 on `edge`, otherwise increments, saturating at all-ones.
- FSM states:
  - IDLE=0: waits for `arm`.
  - SEEK=1: waits for the first `edge`, then goes to VERIFY with `good=0`.
  - VERIFY=2: on each `edge`:
    - If `per_cnt==sysref_period`, increment `good`.
    - Otherwise set `err_period` and set `good=0`.
    - When `good` would reach LOCK_COUNT, go to RUN.
  - RUN=3: LMFC is free-running; phase is checked on every `edge`.
- Timeout: in VERIFY or RUN, if `per_cnt > 2*sysref_period`, set `err_period` and go to SEEK.
- LMFC counter:
  - On the VERIFY→RUN edge, `lmfc_cnt` loads 0 the next cycle.
  - Otherwise it increments modulo LMFC_PERIOD in RUN.
  - It is held at 0 outside RUN.
- RUN check: on each `edge`, the required values are `lmfc_cnt==LMFC_PERIOD-1` and `per_cnt==sysref_period`. On any mismatch:
  - Set `err_phase` and/or `err_period`.
  - Increment `realign_cnt`.
  - Go to VERIFY with `good=0`.
- `locked` is 1 only in RUN.
- `link_reset`:
  - 1 in every state except RUN.
  - In RUN it deasserts after RST_HOLD cycles and reasserts the cycle after RUN is left.
- `arm` in any state except IDLE: go to SEEK. This clears `good`, `per_cnt`, the hold counter and the sticky errors.
- `arm` in IDLE: go to SEEK and clear the sticky errors.
- Simultaneous `arm` and `edge`: `arm` wins and the edge is discarded.
- `reset`, including mid-operation, drives all outputs to their reset values next cycle:
  - `state`=IDLE.
  - `lmfc_cnt`=0, `lmfc_pulse`=0.
  - `locked`=0, `link_reset`=1.
  - Errors 0, `realign_cnt`=0.
  - Synchronizer flops 0.

## Timing
- `sysref` rising edge to `edge`: 2–3 cycles, due to the synchronizer plus edge detect.
- All outputs are registered.
- Last verifying `edge` in cycle N:
  - `state`=RUN and `locked`=1 in N+1.
  - `lmfc_cnt`=0 and `lmfc_pulse`=1 in N+1.
  - `link_reset`=0 in N+1+RST_HOLD.
- Mismatch `edge` in cycle M: `locked`=0, the error flag set, `link_reset`=1, and `realign_cnt` incremented, all in M+1.
- `arm` in cycle A: `state`=SEEK in A+1.

## Structure
- Shared package `jesd204_pkg` holds the FSM state encoding (IDLE/SEEK/VERIFY/RUN, 3-bit) and the default constants for LMFC_PERIOD and LOCK_COUNT.
- One sub-module, `jesd204_sysref_sync`: 2-flop synchronizer plus rising-edge detector, with synchronous active-high reset and output `edge`.

## Test plan
- Basic lock: `sysref_period`=128, LMFC_PERIOD=32, SYSREF every 128 cycles, `arm` → `locked` one cycle after the 5th edge; `lmfc_pulse` every 32 cycles, coincident with the cycle after each `edge`; `link_reset` low 16 cycles after lock.
- Period error during VERIFY: one SYSREF gap of 127 → `err_period`=1, lock delayed until 4 further good periods.
- Phase slip in RUN: shift SYSREF by 8 cycles → `err_phase`=1, `locked`=0, `realign_cnt`=1, `link_reset`=1; relock after 4 good periods at the new phase.
- Lost SYSREF in RUN: stop SYSREF → SEEK after 257 cycles, `err_period`=1.
- `arm` coincident with an `edge` while in RUN → SEEK, edge ignored, errors cleared, relock after 5 edges.
- `reset` asserted in RUN → next cycle `state`=0, `link_reset`=1, `locked`=0, `lmfc_cnt`=0, counters and errors 0.

Source files
------------

// File: rtl/jesd204_pkg.sv
// Shared definitions for the JESD204 SYSREF / LMFC alignment controller.
//   state_t          : controller FSM encoding (3 bits, IDLE/SEEK/VERIFY/RUN)
//   LMFC_PERIOD_DEF  : default coreclk cycles per LMFC
//   LOCK_COUNT_DEF   : default number of consecutive good SYSREF periods for lock
//   width_of()       : bits needed to hold values 0..max_value (never less than 1)
package jesd204_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SEEK   = 3'd1,
        ST_VERIFY = 3'd2,
        ST_RUN    = 3'd3
    } state_t;

    localparam int LMFC_PERIOD_DEF = 32;
    localparam int LOCK_COUNT_DEF  = 4;

    function automatic int width_of(input int max_value);
        return (max_value < 2) ? 1 : $clog2(max_value + 1);
    endfunction

endpackage

// File: rtl/jesd204_sysref_sync.sv
// SYSREF input conditioning: two-flop synchronizer into the local clock
// domain followed by a rising-edge detector.
//   clk         : local clock
//   srst        : synchronous active-high reset, clears all flops
//   sysref      : raw SYSREF, asynchronous to clk
//   sysref_edge : one-cycle pulse per synchronized rising edge
module jesd204_sysref_sync (
    input  logic clk,
    input  logic srst,
    input  logic sysref,
    output logic sysref_edge
);

    // [0],[1] form the synchronizer, [2] holds the previous synchronized level
    logic [2:0] sync_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[1:0], sysref};
        end
    end

    assign sysref_edge = sync_reg[1] & ~sync_reg[2];

endmodule

// File: rtl/jesd204_sysref_ctrl.sv
// JESD204 link bring-up sequencer. Verifies that SYSREF is periodic at the
// programmed period, aligns a local LMFC counter to it, monitors its phase
// while running and holds the JESD core in reset until alignment is proven.
//   coreclk       : single clock
//   reset         : synchronous active-high reset
//   sysref        : board SYSREF (asynchronous)
//   arm           : one-cycle request to (re)start alignment
//   sysref_period : expected SYSREF spacing in coreclk cycles (multiple of LMFC_PERIOD)
//   lmfc_cnt      : LMFC phase, lmfc_pulse marks phase 0 while running
//   locked        : SYSREF verified and LMFC aligned
//   link_reset    : reset to the JESD core / transceivers
//   state         : FSM state, err_period / err_phase sticky error flags
//   realign_cnt   : saturating count of lock losses
module jesd204_sysref_ctrl
    import jesd204_pkg::*;
#(
    parameter int LMFC_PERIOD = LMFC_PERIOD_DEF,
    parameter int PERIOD_W    = 16,
    parameter int LOCK_COUNT  = LOCK_COUNT_DEF,
    parameter int RST_HOLD    = 16
) (
    input  logic                           coreclk,
    input  logic                           reset,
    input  logic                           sysref,
    input  logic                           arm,
    input  logic [PERIOD_W-1:0]            sysref_period,
    output logic [$clog2(LMFC_PERIOD)-1:0] lmfc_cnt,
    output logic                           lmfc_pulse,
    output logic                           locked,
    output logic                           link_reset,
    output logic [2:0]                     state,
    output logic                           err_period,
    output logic                           err_phase,
    output logic [7:0]                     realign_cnt
);

    localparam int LMFC_W = $clog2(LMFC_PERIOD);
    localparam int HOLD_W = width_of(RST_HOLD);
    localparam logic [LMFC_W-1:0] LMFC_LAST   = LMFC_W'(LMFC_PERIOD - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX    = HOLD_W'(RST_HOLD);
    localparam logic [3:0]        LOCK_TARGET = 4'(LOCK_COUNT);

    state_t              state_reg, state_next;
    logic [PERIOD_W-1:0] per_cnt_reg, per_cnt_next;
    logic [3:0]          good_reg, good_next;
    logic [HOLD_W-1:0]   hold_reg, hold_next;
    logic [LMFC_W-1:0]   lmfc_reg, lmfc_next;
    logic                pulse_reg, pulse_next;
    logic                locked_reg, locked_next;
    logic                link_reset_reg, link_reset_next;
    logic                err_period_reg, err_period_next;
    logic                err_phase_reg, err_phase_next;
    logic [7:0]          realign_reg, realign_next;

    logic                sysref_edge;
    logic                period_ok;
    logic                phase_ok;
    logic                timeout;
    logic [3:0]          good_inc;

    jesd204_sysref_sync u_sync (
        .clk         (coreclk),
        .srst        (reset),
        .sysref      (sysref),
        .sysref_edge (sysref_edge)
    );

    assign period_ok = (per_cnt_reg == sysref_period);
    assign phase_ok  = (lmfc_reg == LMFC_LAST);
    assign good_inc  = good_reg + 4'd1;
    // Widened compare so 2*sysref_period cannot overflow
    assign timeout   = ((state_reg == ST_VERIFY) || (state_reg == ST_RUN)) &&
                       ({1'b0, per_cnt_reg} > {sysref_period, 1'b0});

    // State and datapath registers
    always_ff @(posedge coreclk) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            per_cnt_reg    <= '0;
            good_reg       <= '0;
            hold_reg       <= '0;
            lmfc_reg       <= '0;
            pulse_reg      <= 1'b0;
            locked_reg     <= 1'b0;
            link_reset_reg <= 1'b1;
            err_period_reg <= 1'b0;
            err_phase_reg  <= 1'b0;
            realign_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            per_cnt_reg    <= per_cnt_next;
            good_reg       <= good_next;
            hold_reg       <= hold_next;
            lmfc_reg       <= lmfc_next;
            pulse_reg      <= pulse_next;
            locked_reg     <= locked_next;
            link_reset_reg <= link_reset_next;
            err_period_reg <= err_period_next;
            err_phase_reg  <= err_phase_next;
            realign_reg    <= realign_next;
        end
    end

    // Next-state logic, including the event-driven good count and sticky flags.
    // arm has priority over everything, so a coincident edge is dropped.
    always_comb begin
        state_next      = state_reg;
        good_next       = good_reg;
        err_period_next = err_period_reg;
        err_phase_next  = err_phase_reg;
        realign_next    = realign_reg;
        if (arm) begin
            state_next      = ST_SEEK;
            good_next       = '0;
            err_period_next = 1'b0;
            err_phase_next  = 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: ;
                ST_SEEK: begin
                    if (sysref_edge) begin
                        state_next = ST_VERIFY;
                        good_next  = '0;
                    end
                end
                ST_VERIFY: begin
                    if (sysref_edge) begin
                        if (period_ok) begin
                            if (good_inc == LOCK_TARGET) begin
                                state_next = ST_RUN;
                                good_next  = '0;
                            end else begin
                                good_next = good_inc;
                            end
                        end else begin
                            err_period_next = 1'b1;
                            good_next       = '0;
                        end
                    end else if (timeout) begin
                        err_period_next = 1'b1;
                        good_next       = '0;
                        state_next      = ST_SEEK;
                    end
                end
                ST_RUN: begin
                    if (sysref_edge) begin
                        if (!period_ok || !phase_ok) begin
                            if (!period_ok) err_period_next = 1'b1;
                            if (!phase_ok)  err_phase_next  = 1'b1;
                            if (realign_reg != 8'hFF) realign_next = realign_reg + 8'd1;
                            good_next  = '0;
                            state_next = ST_VERIFY;
                        end
                    end else if (timeout) begin
                        err_period_next = 1'b1;
                        state_next      = ST_SEEK;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Output / counter logic, computed from the next state so every output
    // is a plain register and reflects a state change in the same cycle.
    always_comb begin
        if (arm) begin
            per_cnt_next = '0;
        end else if (sysref_edge) begin
            per_cnt_next = PERIOD_W'(1);
        end else if (&per_cnt_reg) begin
            per_cnt_next = per_cnt_reg;
        end else begin
            per_cnt_next = per_cnt_reg + PERIOD_W'(1);
        end

        lmfc_next = '0;
        hold_next = '0;
        if (state_next == ST_RUN && state_reg == ST_RUN) begin
            lmfc_next = (lmfc_reg == LMFC_LAST) ? '0 : lmfc_reg + LMFC_W'(1);
            hold_next = (hold_reg == HOLD_MAX) ? hold_reg : hold_reg + HOLD_W'(1);
        end

        pulse_next      = (state_next == ST_RUN) && (lmfc_next == '0);
        locked_next     = (state_next == ST_RUN);
        link_reset_next = !((state_next == ST_RUN) && (hold_next >= HOLD_MAX));
    end

    assign lmfc_cnt    = lmfc_reg;
    assign lmfc_pulse  = pulse_reg;
    assign locked      = locked_reg;
    assign link_reset  = link_reset_reg;
    assign state       = state_reg;
    assign err_period  = err_period_reg;
    assign err_phase   = err_phase_reg;
    assign realign_cnt = realign_reg;

endmodule

// File: tb/tb_jesd204_sysref_ctrl.sv
// Directed bench for jesd204_sysref_ctrl: lock, VERIFY period error, RUN
// phase slip, arm racing an edge, lost SYSREF and reset in RUN.
module tb_jesd204_sysref_ctrl;

    logic        coreclk;
    logic        reset;
    logic        sysref;
    logic        arm;
    logic [15:0] sysref_period;
    logic [4:0]  lmfc_cnt;
    logic        lmfc_pulse;
    logic        locked;
    logic        link_reset;
    logic [2:0]  state;
    logic        err_period;
    logic        err_phase;
    logic [7:0]  realign_cnt;

    int vectors     = 0;
    int miscompares = 0;
    int t           = 0;
    int last_start  = 0;

    jesd204_sysref_ctrl #(
        .LMFC_PERIOD (32),
        .PERIOD_W    (16),
        .LOCK_COUNT  (4),
        .RST_HOLD    (16)
    ) dut (
        .coreclk       (coreclk),
        .reset         (reset),
        .sysref        (sysref),
        .arm           (arm),
        .sysref_period (sysref_period),
        .lmfc_cnt      (lmfc_cnt),
        .lmfc_pulse    (lmfc_pulse),
        .locked        (locked),
        .link_reset    (link_reset),
        .state         (state),
        .err_period    (err_period),
        .err_phase     (err_phase),
        .realign_cnt   (realign_cnt)
    );

    initial begin
        coreclk = 1'b0;
        forever #5 coreclk = ~coreclk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        vectors++;
        assert (obs === want)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h (t=%0d)", tag, obs, want, t);
        end
    endtask

    // Every step ends on a falling edge: inputs change and outputs are sampled there
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge coreclk);
            t++;
        end
    endtask

    task automatic wait_until(input int target);
        while (t < target) step(1);
    endtask

    // SYSREF high for 3 cycles; returns when the DUT response to its edge is visible
    task automatic pulse();
        last_start = t;
        sysref = 1'b1;
        step(3);
        sysref = 1'b0;
    endtask

    task automatic next_pulse(input int gap);
        wait_until(last_start + gap);
        pulse();
    endtask

    task automatic arm_pulse();
        arm = 1'b1;
        step(1);
        arm = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        sysref        = 1'b0;
        arm           = 1'b0;
        sysref_period = 16'd128;
        step(3);

        // Reset values
        check("rst_state", 32'(state), 32'd0);
        check("rst_link_reset", 32'(link_reset), 32'd1);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_lmfc", 32'(lmfc_cnt), 32'd0);
        check("rst_pulse", 32'(lmfc_pulse), 32'd0);
        check("rst_realign", 32'(realign_cnt), 32'd0);
        reset = 1'b0;
        step(2);
        check("idle_state", 32'(state), 32'd0);

        // Basic lock
        arm_pulse();
        check("arm_seek", 32'(state), 32'd1);
        step(2);
        pulse();
        check("e1_verify", 32'(state), 32'd2);
        for (int i = 2; i <= 4; i++) begin
            next_pulse(128);
            check("e_verify", 32'(state), 32'd2);
            check("e_unlocked", 32'(locked), 32'd0);
        end
        next_pulse(128);
        check("lock_state", 32'(state), 32'd3);
        check("lock_locked", 32'(locked), 32'd1);
        check("lock_lmfc0", 32'(lmfc_cnt), 32'd0);
        check("lock_pulse", 32'(lmfc_pulse), 32'd1);
        check("lock_lrst_hi", 32'(link_reset), 32'd1);
        check("lock_err", 32'({err_period, err_phase}), 32'd0);
        step(1);
        check("lmfc1", 32'(lmfc_cnt), 32'd1);
        check("pulse_off", 32'(lmfc_pulse), 32'd0);
        step(14);
        check("lrst_hold", 32'(link_reset), 32'd1);
        step(1);
        check("lrst_release", 32'(link_reset), 32'd0);
        step(15);
        check("lmfc31", 32'(lmfc_cnt), 32'd31);
        check("lmfc31_pulse", 32'(lmfc_pulse), 32'd0);
        step(1);
        check("lmfc_wrap", 32'(lmfc_cnt), 32'd0);
        check("lmfc_wrap_pulse", 32'(lmfc_pulse), 32'd1);
        next_pulse(128);
        check("run_edge_locked", 32'(locked), 32'd1);
        check("run_edge_lmfc", 32'(lmfc_cnt), 32'd0);
        check("run_edge_pulse", 32'(lmfc_pulse), 32'd1);
        check("run_edge_phase", 32'(err_phase), 32'd0);

        // Period error during VERIFY
        step(5);
        arm_pulse();
        check("rearm_seek", 32'(state), 32'd1);
        check("rearm_lrst", 32'(link_reset), 32'd1);
        step(2);
        pulse();
        next_pulse(128);
        check("v_good1", 32'(state), 32'd2);
        check("v_noerr", 32'(err_period), 32'd0);
        next_pulse(127);
        check("v_short_err", 32'(err_period), 32'd1);
        check("v_short_state", 32'(state), 32'd2);
        for (int i = 0; i < 3; i++) begin
            next_pulse(128);
            check("v_regood", 32'(state), 32'd2);
        end
        next_pulse(128);
        check("v_relock", 32'(state), 32'd3);
        check("v_relock_locked", 32'(locked), 32'd1);

        // Phase slip in RUN
        next_pulse(128);
        check("slip_pre_locked", 32'(locked), 32'd1);
        next_pulse(136);
        check("slip_phase", 32'(err_phase), 32'd1);
        check("slip_period", 32'(err_period), 32'd1);
        check("slip_locked", 32'(locked), 32'd0);
        check("slip_lrst", 32'(link_reset), 32'd1);
        check("slip_realign", 32'(realign_cnt), 32'd1);
        check("slip_state", 32'(state), 32'd2);
        for (int i = 0; i < 3; i++) begin
            next_pulse(128);
            check("slip_verify", 32'(state), 32'd2);
        end
        next_pulse(128);
        check("slip_relock", 32'(locked), 32'd1);

        // arm coincident with an edge in RUN: arm wins
        wait_until(last_start + 128);
        last_start = t;
        sysref = 1'b1;
        step(2);
        arm = 1'b1;
        step(1);
        arm = 1'b0;
        sysref = 1'b0;
        check("armedge_state", 32'(state), 32'd1);
        check("armedge_errs", 32'({err_period, err_phase}), 32'd0);
        check("armedge_locked", 32'(locked), 32'd0);
        check("armedge_realign", 32'(realign_cnt), 32'd1);
        next_pulse(128);
        check("armedge_e1", 32'(state), 32'd2);
        for (int i = 0; i < 3; i++) begin
            next_pulse(128);
            check("armedge_verify", 32'(state), 32'd2);
        end
        next_pulse(128);
        check("armedge_relock", 32'(state), 32'd3);

        // Lost SYSREF in RUN
        wait_until(last_start + 259);
        check("lost_still_run", 32'(state), 32'd3);
        check("lost_no_err", 32'(err_period), 32'd0);
        step(1);
        check("lost_seek", 32'(state), 32'd1);
        check("lost_err", 32'(err_period), 32'd1);
        check("lost_locked", 32'(locked), 32'd0);
        check("lost_lrst", 32'(link_reset), 32'd1);

        // Reset asserted in RUN
        step(3);
        pulse();
        for (int i = 0; i < 4; i++) next_pulse(128);
        step(20);
        check("pre_rst_locked", 32'(locked), 32'd1);
        check("pre_rst_lrst", 32'(link_reset), 32'd0);
        check("pre_rst_err", 32'(err_period), 32'd1);
        reset = 1'b1;
        step(1);
        check("mid_rst_state", 32'(state), 32'd0);
        check("mid_rst_lrst", 32'(link_reset), 32'd1);
        check("mid_rst_locked", 32'(locked), 32'd0);
        check("mid_rst_lmfc", 32'(lmfc_cnt), 32'd0);
        check("mid_rst_pulse", 32'(lmfc_pulse), 32'd0);
        check("mid_rst_errs", 32'({err_period, err_phase}), 32'd0);
        check("mid_rst_realign", 32'(realign_cnt), 32'd0);
        reset = 1'b0;
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
